spm_access_arbiter: RTL and testbench
=====================================

// Module: spm_access_arbiter
// PURPOSE
//  Shares the 2048x32 byte-writable data scratchpad between the CPU load/store port and a DMA burst engine.
//  CPU gets single-cycle access priority; a starvation counter forces DMA slots.
//  Internal burst sequencer walks address/length for DMA read (SPM->DMA) and write (DMA->SPM) bursts.
//  Sits between or1420 data-memory path, DMA bridge and the scratchpad RAM; SPM read latency is 1 cycle.
// PARAMETERS
//  ADDR_WIDTH  11  SPM word-address width; addresses wrap modulo 2**ADDR_WIDTH
//  MAX_STALL   4   consecutive CPU-won cycles tolerated while DMA waits, then one forced DMA slot (>=1)
// PORTS
//  clock            in   1   system clock, all state on rising edge
//  resetN           in   1   asynchronous active-low reset
//  cpuReq           in   1   CPU access request this cycle
//  cpuByteWe        in   4   CPU byte write enables; 0000 = read
//  cpuAddr          in   ADDR_WIDTH  CPU word address
//  cpuWdata         in   32  CPU write data
//  cpuGrant         out  1   combinational: CPU access performed this cycle
//  cpuRdata         out  32  read data (spmDataOut passthrough)
//  cpuRvalid        out  1   registered: cpuRdata valid for read granted previous cycle
//  dmaStart         in   1   pulse: begin burst (ignored unless IDLE)
//  dmaWrite         in   1   sampled at start: 1 = DMA->SPM, 0 = SPM->DMA
//  dmaAddr          in   ADDR_WIDTH  sampled at start: first word address
//  dmaLen           in   ADDR_WIDTH+1  sampled at start: word count, 0..2**ADDR_WIDTH
//  dmaWdata         in   32  write-burst data
//  dmaWvalid        in   1   dmaWdata valid
//  dmaWready        out  1   combinational: dmaWdata consumed this cycle
//  dmaRdata         out  32  read data (spmDataOut passthrough)
//  dmaRvalid        out  1   registered: dmaRdata valid
//  dmaBusy          out  1   state != IDLE
//  dmaDone          out  1   one-cycle pulse at burst completion
//  spmByteWe        out  4   to SPM byte write enables
//  spmAddress       out  ADDR_WIDTH  to SPM address
//  spmDataIn        out  32  to SPM write data
//  spmDataOut       in   32  from SPM, valid one cycle after address
// BEHAVIOUR
//  Reset: FSM IDLE, counters 0, cpuRvalid/dmaRvalid/dmaDone/dmaBusy 0; spm outputs default to 0 (no write).
//  Reset mid-burst aborts burst: no dmaDone, no pending rvalid delivered.
//  FSM: IDLE -(dmaStart, len!=0)-> RUN; IDLE -(dmaStart, len==0)-> DONE.
//   RUN -(last word issued, write)-> DONE; RUN -(last word issued, read)-> DRAIN.
//   DRAIN -> DONE (last dmaRvalid this cycle); DONE -> IDLE (dmaDone=1).
//  dmaWant = RUN && (!dir_write || dmaWvalid).
//  Slot: dmaSlot = dmaWant && (!cpuReq || stall==MAX_STALL); cpuGrant = cpuReq && !dmaSlot.
//  Neither: spmByteWe=0000, address/data held from CPU port (harmless read).
//  CPU slot: spm <= cpuByteWe/cpuAddr/cpuWdata; cpuRvalid next cycle iff cpuByteWe==0.
//  DMA slot: write -> spmByteWe=1111, data=dmaWdata, dmaWready=1; read -> spmByteWe=0000, dmaRvalid next cycle.
//   Each DMA slot: addr<=addr+1 (wrap), remaining<=remaining-1.
//  stall counter: +1 on cycles cpuGrant && dmaWant; cleared on any dmaSlot or !dmaWant; saturates at MAX_STALL.
//  Write burst with dmaWvalid=0: no slot, no advance, stall not incremented.
//  dmaStart during non-IDLE ignored; operands sampled only in IDLE.
//  Simultaneous cpu/dma reads: SPM shared, both rvalid flags never high same cycle.
// STRUCTURE
//  Shared include spm_ctrl_defs.vh: FSM state encodings (IDLE, RUN, DRAIN, DONE), SPM_DATA_WIDTH=32, SPM_BE_WIDTH=4.
//  Sub-module spm_burst_counter: loadable address incrementer + remaining-length down-counter, 'last' flag.
//  Top holds FSM, stall counter, slot mux, rvalid pipeline flops.
// TESTING
//  CPU only: write 0xDEADBEEF be=1111 @0x010, read @0x010 -> cpuGrant same cycle, cpuRvalid+1 cycle, data 0xDEADBEEF.
//  Byte lanes: be=0010 data 0x0000AB00 over 0x11223344 -> read 0x1122AB44.
//  DMA read len=4 @0x7FE, CPU idle -> addresses 0x7FE,0x7FF,0x000,0x001; 4 dmaRvalid; dmaDone 2 cycles after last issue.
//  Contention: cpuReq held high, DMA write len=3, MAX_STALL=4 -> DMA slot every 5th cycle; dmaDone after 15 cycles of RUN.
//  dmaLen=0 -> dmaBusy 1 cycle (DONE), dmaDone pulse, no SPM write; dmaStart mid-burst ignored.
//  resetN low during RUN -> dmaBusy=0, no dmaDone, outputs zero; new burst starts cleanly after release.

Source files
------------

// File: rtl/spm_access_arbiter_pkg.sv
// Shared definitions for the scratchpad access arbiter: data/byte-enable widths
// and the DMA burst FSM state encoding.
package spm_access_arbiter_pkg;

    localparam int SPM_DATA_WIDTH = 32;
    localparam int SPM_BE_WIDTH   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/spm_access_arbiter_burst_counter.sv
// DMA burst walker: loadable word-address incrementer (wraps at the SPM size)
// and remaining-word down-counter with a flag for the final word.
module spm_access_arbiter_burst_counter
    import spm_access_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    input  logic                  step_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o
);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;

    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        if (load_i) begin
            addr_d      = addr_i;
            remaining_d = len_i;
        end else if (step_i) begin
            addr_d      = addr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            addr_q      <= '0;
            remaining_q <= '0;
        end else begin
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (remaining_q == (ADDR_WIDTH+1)'(1));

endmodule

// File: rtl/spm_access_arbiter.sv
// Arbitrates the single-port data scratchpad between the CPU load/store port
// (priority) and a DMA burst engine, with a starvation limit on DMA waits.
module spm_access_arbiter
    import spm_access_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int MAX_STALL  = 4
) (
    input  logic                      clock,
    input  logic                      resetN,
    input  logic                      cpuReq,
    input  logic [SPM_BE_WIDTH-1:0]   cpuByteWe,
    input  logic [ADDR_WIDTH-1:0]     cpuAddr,
    input  logic [SPM_DATA_WIDTH-1:0] cpuWdata,
    output logic                      cpuGrant,
    output logic [SPM_DATA_WIDTH-1:0] cpuRdata,
    output logic                      cpuRvalid,
    input  logic                      dmaStart,
    input  logic                      dmaWrite,
    input  logic [ADDR_WIDTH-1:0]     dmaAddr,
    input  logic [ADDR_WIDTH:0]       dmaLen,
    input  logic [SPM_DATA_WIDTH-1:0] dmaWdata,
    input  logic                      dmaWvalid,
    output logic                      dmaWready,
    output logic [SPM_DATA_WIDTH-1:0] dmaRdata,
    output logic                      dmaRvalid,
    output logic                      dmaBusy,
    output logic                      dmaDone,
    output logic [SPM_BE_WIDTH-1:0]   spmByteWe,
    output logic [ADDR_WIDTH-1:0]     spmAddress,
    output logic [SPM_DATA_WIDTH-1:0] spmDataIn,
    input  logic [SPM_DATA_WIDTH-1:0] spmDataOut
);

    localparam int                 STALL_W   = $clog2(MAX_STALL + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(MAX_STALL);

    arb_state_e           state_q, state_d;
    logic                 dir_q, dir_d;
    logic [STALL_W-1:0]   stall_q, stall_d;
    logic                 cpu_rvalid_q, cpu_rvalid_d;
    logic                 dma_rvalid_q, dma_rvalid_d;

    logic                  burst_load;
    logic                  burst_last;
    logic [ADDR_WIDTH-1:0] burst_addr;
    logic                  dma_want;
    logic                  dma_slot;
    logic                  cpu_grant;

    assign burst_load = (state_q == ST_IDLE) && dmaStart;
    assign dma_want   = (state_q == ST_RUN) && (!dir_q || dmaWvalid);
    assign dma_slot   = dma_want && (!cpuReq || (stall_q == STALL_MAX));
    // Gated by reset so nothing reaches the SPM while the block is held in reset.
    assign cpu_grant  = cpuReq && !dma_slot && resetN;

    spm_access_arbiter_burst_counter #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_burst (
        .clock  (clock),
        .resetN (resetN),
        .load_i (burst_load),
        .addr_i (dmaAddr),
        .len_i  (dmaLen),
        .step_i (dma_slot),
        .addr_o (burst_addr),
        .last_o (burst_last)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        unique case (state_q)
            ST_IDLE: begin
                if (dmaStart) begin
                    dir_d   = dmaWrite;
                    state_d = (dmaLen == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (dma_slot && burst_last) begin
                    state_d = dir_q ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (dma_slot || !dma_want) begin
            stall_d = '0;
        end else if (cpu_grant && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + 1'b1;
        end
        cpu_rvalid_d = cpu_grant && (cpuByteWe == '0);
        dma_rvalid_d = dma_slot && !dir_q;
    end

    // With no owner the CPU address/data stay on the bus as a harmless read.
    always_comb begin
        spmByteWe  = '0;
        spmAddress = cpuAddr;
        spmDataIn  = cpuWdata;
        if (!resetN) begin
            spmAddress = '0;
            spmDataIn  = '0;
        end else if (dma_slot) begin
            spmByteWe  = dir_q ? '1 : '0;
            spmAddress = burst_addr;
            spmDataIn  = dmaWdata;
        end else if (cpu_grant) begin
            spmByteWe  = cpuByteWe;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q      <= ST_IDLE;
            dir_q        <= 1'b0;
            stall_q      <= '0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            stall_q      <= stall_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dma_rvalid_q <= dma_rvalid_d;
        end
    end

    assign cpuGrant  = cpu_grant;
    assign dmaWready = dma_slot && dir_q;
    assign cpuRdata  = spmDataOut;
    assign dmaRdata  = spmDataOut;
    assign cpuRvalid = cpu_rvalid_q;
    assign dmaRvalid = dma_rvalid_q;
    assign dmaBusy   = (state_q != ST_IDLE);
    assign dmaDone   = (state_q == ST_DONE);

endmodule

// File: tb/tb_spm_access_arbiter.sv
// Bench for spm_access_arbiter: scratchpad RAM model, table-driven CPU vectors,
// directed DMA/contention/reset sequences and random traffic against a reference model.
module tb_spm_access_arbiter;

    localparam int AW    = 11;
    localparam int MAXS  = 4;
    localparam int DEPTH = 2048;

    logic          clock = 1'b0;
    logic          resetN;
    logic          cpuReq;
    logic [3:0]    cpuByteWe;
    logic [AW-1:0] cpuAddr;
    logic [31:0]   cpuWdata;
    logic          cpuGrant;
    logic [31:0]   cpuRdata;
    logic          cpuRvalid;
    logic          dmaStart;
    logic          dmaWrite;
    logic [AW-1:0] dmaAddr;
    logic [AW:0]   dmaLen;
    logic [31:0]   dmaWdata;
    logic          dmaWvalid;
    logic          dmaWready;
    logic [31:0]   dmaRdata;
    logic          dmaRvalid;
    logic          dmaBusy;
    logic          dmaDone;
    logic [3:0]    spmByteWe;
    logic [AW-1:0] spmAddress;
    logic [31:0]   spmDataIn;
    logic [31:0]   spmDataOut;

    always #5 clock = ~clock;

    spm_access_arbiter #(.ADDR_WIDTH(AW), .MAX_STALL(MAXS)) dut (
        .clock(clock), .resetN(resetN),
        .cpuReq(cpuReq), .cpuByteWe(cpuByteWe), .cpuAddr(cpuAddr), .cpuWdata(cpuWdata),
        .cpuGrant(cpuGrant), .cpuRdata(cpuRdata), .cpuRvalid(cpuRvalid),
        .dmaStart(dmaStart), .dmaWrite(dmaWrite), .dmaAddr(dmaAddr), .dmaLen(dmaLen),
        .dmaWdata(dmaWdata), .dmaWvalid(dmaWvalid), .dmaWready(dmaWready),
        .dmaRdata(dmaRdata), .dmaRvalid(dmaRvalid), .dmaBusy(dmaBusy), .dmaDone(dmaDone),
        .spmByteWe(spmByteWe), .spmAddress(spmAddress), .spmDataIn(spmDataIn),
        .spmDataOut(spmDataOut)
    );

    // Scratchpad RAM: byte-writable, one-cycle read latency.
    logic [31:0] spm_mem [0:DEPTH-1];
    logic        clear_mem;
    always @(posedge clock) begin
        if (clear_mem) begin
            for (int i = 0; i < DEPTH; i++) spm_mem[i] <= 32'h0;
            spmDataOut <= 32'h0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (spmByteWe[b]) spm_mem[spmAddress][8*b +: 8] <= spmDataIn[8*b +: 8];
            spmDataOut <= spm_mem[spmAddress];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: expected memory image, queue of burst words still to issue.
    logic [31:0] ref_mem [0:DEPTH-1];
    int unsigned q_addr[$];
    bit          m_active, m_write;
    int          stall_m;
    int          done_at;
    int          cyc = 0;
    bit          e_crv, e_drv;
    logic [31:0] e_cdata, e_ddata;

    logic          obs_grant, obs_wready, obs_busy, obs_done, obs_crv, obs_drv;
    logic [3:0]    obs_be;
    logic [AW-1:0] obs_addr;
    logic [31:0]   obs_crdata, obs_drdata;

    task automatic model_reset();
        q_addr.delete();
        m_active = 0;
        m_write  = 0;
        stall_m  = 0;
        done_at  = -1;
        e_crv    = 0;
        e_drv    = 0;
    endtask

    task automatic cpu_in(input logic req, input logic [3:0] be, input logic [AW-1:0] a, input logic [31:0] d);
        cpuReq = req; cpuByteWe = be; cpuAddr = a; cpuWdata = d;
    endtask

    task automatic dma_in(input logic st, input logic wr, input logic [AW-1:0] a, input logic [AW:0] len,
                          input logic [31:0] d, input logic wv);
        dmaStart = st; dmaWrite = wr; dmaAddr = a; dmaLen = len; dmaWdata = d; dmaWvalid = wv;
    endtask

    // One clock: entered at posedge+1 with inputs driven, checks at the falling edge.
    task automatic tick();
        bit want, slot, grant, n_crv, n_drv;
        logic [31:0] n_cdata, n_ddata;
        int unsigned a;
        #4;
        obs_grant = cpuGrant;   obs_wready = dmaWready; obs_busy = dmaBusy;
        obs_done  = dmaDone;    obs_crv    = cpuRvalid; obs_drv  = dmaRvalid;
        obs_be    = spmByteWe;  obs_addr   = spmAddress;
        obs_crdata = cpuRdata;  obs_drdata = dmaRdata;

        want  = m_active && (q_addr.size() > 0) && (!m_write || dmaWvalid);
        slot  = want && (!cpuReq || stall_m == MAXS);
        grant = cpuReq && !slot;

        chk1("cpuGrant", cpuGrant, grant);
        chk1("dmaWready", dmaWready, slot && m_write);
        chk1("dmaBusy", dmaBusy, m_active);
        chk1("dmaDone", dmaDone, m_active && (cyc == done_at));
        chk1("cpuRvalid", cpuRvalid, e_crv);
        chk1("dmaRvalid", dmaRvalid, e_drv);
        if (e_crv) chk32("cpuRdata", cpuRdata, e_cdata);
        if (e_drv) chk32("dmaRdata", dmaRdata, e_ddata);
        if (slot) begin
            chk32("spm_addr_dma", 32'(spmAddress), q_addr[0]);
            chk32("spm_be_dma", 32'(spmByteWe), m_write ? 32'hF : 32'h0);
            if (m_write) chk32("spm_wdata_dma", spmDataIn, dmaWdata);
        end else if (grant) begin
            chk32("spm_addr_cpu", 32'(spmAddress), 32'(cpuAddr));
            chk32("spm_be_cpu", 32'(spmByteWe), 32'(cpuByteWe));
            if (cpuByteWe != 4'h0) chk32("spm_wdata_cpu", spmDataIn, cpuWdata);
        end else begin
            chk32("spm_be_idle", 32'(spmByteWe), 32'h0);
        end

        n_crv = 0; n_drv = 0; n_cdata = 32'h0; n_ddata = 32'h0;
        if (grant) begin
            if (cpuByteWe == 4'h0) begin
                n_crv = 1; n_cdata = ref_mem[cpuAddr];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (cpuByteWe[b]) ref_mem[cpuAddr][8*b +: 8] = cpuWdata[8*b +: 8];
            end
        end
        if (slot) begin
            a = q_addr.pop_front();
            if (m_write) ref_mem[a] = dmaWdata;
            else begin n_drv = 1; n_ddata = ref_mem[a]; end
            if (q_addr.size() == 0) done_at = cyc + (m_write ? 1 : 2);
        end
        if (slot || !want) stall_m = 0;
        else if (grant && stall_m < MAXS) stall_m++;
        if (!m_active && dmaStart) begin
            m_active = 1;
            m_write  = dmaWrite;
            for (int i = 0; i < int'(dmaLen); i++) q_addr.push_back((int'(dmaAddr) + i) % DEPTH);
            if (dmaLen == '0) done_at = cyc + 1;
        end else if (m_active && cyc == done_at) begin
            m_active = 0;
            done_at  = -1;
        end
        e_crv = n_crv; e_cdata = n_cdata;
        e_drv = n_drv; e_ddata = n_ddata;
        cyc++;
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic          req;
        logic [3:0]    be;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic          grant;
        logic          rv;
        logic [31:0]   rdata;
    } vec_t;

    vec_t vec [11];

    initial begin
        bit          seen;
        int          cnt, run;
        logic [AW-1:0] exp_addr [4];

        vec[0]  = '{1'b1, 4'hF, 11'h010, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
        vec[1]  = '{1'b1, 4'h0, 11'h010, 32'h0,        1'b1, 1'b1, 32'hDEADBEEF};
        vec[2]  = '{1'b1, 4'hF, 11'h020, 32'h11223344, 1'b1, 1'b0, 32'h0};
        vec[3]  = '{1'b1, 4'h2, 11'h020, 32'h0000AB00, 1'b1, 1'b0, 32'h0};
        vec[4]  = '{1'b1, 4'h0, 11'h020, 32'h0,        1'b1, 1'b1, 32'h1122AB44};
        vec[5]  = '{1'b0, 4'h0, 11'h020, 32'h0,        1'b0, 1'b0, 32'h0};
        vec[6]  = '{1'b1, 4'h1, 11'h7FE, 32'hFFFFFFA5, 1'b1, 1'b0, 32'h0};
        vec[7]  = '{1'b1, 4'hF, 11'h7FF, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0};
        vec[8]  = '{1'b1, 4'hF, 11'h000, 32'h01234567, 1'b1, 1'b0, 32'h0};
        vec[9]  = '{1'b1, 4'h0, 11'h7FE, 32'h0,        1'b1, 1'b1, 32'h000000A5};
        vec[10] = '{1'b0, 4'h0, 11'h000, 32'h0,        1'b0, 1'b0, 32'h0};

        resetN = 1'b0;
        clear_mem = 1'b1;
        cpu_in(1'b1, 4'hF, 11'h055, 32'h12345678);
        dma_in(1'b0, 1'b0, '0, '0, 32'h0, 1'b0);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        clear_mem = 1'b0;
        #2;
        chk1("reset_cpuGrant", cpuGrant, 1'b0);
        chk32("reset_spmByteWe", 32'(spmByteWe), 32'h0);
        chk1("reset_dmaBusy", dmaBusy, 1'b0);
        chk1("reset_dmaDone", dmaDone, 1'b0);
        chk1("reset_cpuRvalid", cpuRvalid, 1'b0);
        chk1("reset_dmaRvalid", dmaRvalid, 1'b0);
        @(posedge clock);
        #1;
        cpu_in(1'b0, 4'h0, '0, 32'h0);
        resetN = 1'b1;
        tick();

        // CPU-only table.
        for (int i = 0; i < 11; i++) begin
            cpu_in(vec[i].req, vec[i].be, vec[i].addr, vec[i].wdata);
            tick();
            chk1("tbl_grant", obs_grant, vec[i].grant);
            if (i > 0) begin
                chk1("tbl_rvalid", obs_crv, vec[i-1].rv);
                if (vec[i-1].rv) chk32("tbl_rdata", obs_crdata, vec[i-1].rdata);
            end
        end

        // DMA read across the address wrap, CPU idle.
        exp_addr[0] = 11'h7FE; exp_addr[1] = 11'h7FF; exp_addr[2] = 11'h000; exp_addr[3] = 11'h001;
        cpu_in(1'b0, 4'h0, 11'h3AA, 32'h0);
        dma_in(1'b1, 1'b0, 11'h7FE, 12'd4, 32'h0, 1'b0);
        tick();
        dmaStart = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk32("dmard_addr", 32'(obs_addr), 32'(exp_addr[i]));
            chk32("dmard_be", 32'(obs_be), 32'h0);
            cnt += int'(obs_drv);
        end
        tick();
        cnt += int'(obs_drv);
        chk1("dmard_drain_rvalid", obs_drv, 1'b1);
        chk1("dmard_drain_nodone", obs_done, 1'b0);
        tick();
        chk1("dmard_done", obs_done, 1'b1);
        chk32("dmard_rvalid_count", cnt, 32'd4);

        // Contention: CPU requests every cycle, DMA write of 3 words.
        cpu_in(1'b1, 4'h0, 11'h010, 32'h0);
        dma_in(1'b1, 1'b1, 11'h100, 12'd3, $urandom, 1'b1);
        tick();
        dmaStart = 1'b0;
        seen = 0; run = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            dmaWdata = $urandom;
            cpuAddr  = 11'($urandom_range(0, 31));
            tick();
            if (obs_done) seen = 1;
            else if (obs_busy) begin
                chk1("contention_slot", obs_wready, (run % 5) == 4);
                run++;
            end
        end
        chk1("contention_done_seen", seen, 1'b1);
        chk32("contention_run_cycles", run, 32'd15);
        cpu_in(1'b0, 4'h0, '0, 32'h0);
        tick();

        // Zero-length burst.
        dma_in(1'b1, 1'b1, 11'h200, 12'd0, 32'hA5A5A5A5, 1'b1);
        tick();
        chk1("len0_start_busy", obs_busy, 1'b0);
        dmaStart = 1'b0;
        tick();
        chk1("len0_busy", obs_busy, 1'b1);
        chk1("len0_done", obs_done, 1'b1);
        chk32("len0_be", 32'(obs_be), 32'h0);
        tick();
        chk1("len0_idle", obs_busy, 1'b0);

        // dmaStart while a stalled write burst is running is ignored.
        dma_in(1'b1, 1'b1, 11'h040, 12'd2, 32'h1, 1'b0);
        tick();
        dma_in(1'b1, 1'b0, 11'h500, 12'd5, 32'h2, 1'b0);
        tick();
        tick();
        chk1("stall_wv0_noready", obs_wready, 1'b0);
        dmaStart = 1'b0;
        dmaWvalid = 1'b1;
        seen = 0; cnt = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            dmaWdata = $urandom;
            tick();
            cnt += int'(obs_wready);
            if (obs_done) seen = 1;
        end
        chk1("ignore_start_done", seen, 1'b1);
        chk32("ignore_start_words", cnt, 32'd2);
        tick();

        // Reset in the middle of a read burst.
        dma_in(1'b1, 1'b0, 11'h300, 12'd8, 32'h0, 1'b0);
        tick();
        dmaStart = 1'b0;
        repeat (3) tick();
        resetN = 1'b0;
        #2;
        chk1("midrst_busy", dmaBusy, 1'b0);
        chk1("midrst_done", dmaDone, 1'b0);
        chk1("midrst_drv", dmaRvalid, 1'b0);
        chk1("midrst_crv", cpuRvalid, 1'b0);
        chk32("midrst_be", 32'(spmByteWe), 32'h0);
        chk32("midrst_addr", 32'(spmAddress), 32'h0);
        repeat (2) @(posedge clock);
        #1;
        resetN = 1'b1;
        model_reset();
        tick();
        chk1("postrst_idle", obs_busy, 1'b0);
        dma_in(1'b1, 1'b1, 11'h301, 12'd2, 32'h0BADF00D, 1'b1);
        tick();
        dmaStart = 1'b0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            if (obs_done) seen = 1;
        end
        chk1("postrst_burst_done", seen, 1'b1);
        cpu_in(1'b1, 4'h0, 11'h302, 32'h0);
        tick();
        cpu_in(1'b0, 4'h0, 11'h0, 32'h0);
        tick();
        chk32("postrst_readback", obs_crdata, 32'h0BADF00D);

        // Random mixed traffic.
        for (int k = 0; k < 800; k++) begin
            cpu_in($urandom_range(0, 9) < 6,
                   ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom),
                   ($urandom_range(0, 1) == 1 ? 11'h7F0 : 11'h000) + 11'($urandom_range(0, 31)),
                   $urandom);
            dma_in($urandom_range(0, 9) == 0, 1'($urandom),
                   ($urandom_range(0, 1) == 1 ? 11'h7F8 : 11'h000) + 11'($urandom_range(0, 15)),
                   12'($urandom_range(0, 6)), $urandom, $urandom_range(0, 9) < 7);
            tick();
        end
        cpu_in(1'b0, 4'h0, '0, 32'h0);
        dma_in(1'b0, 1'b0, '0, '0, 32'h0, 1'b1);
        for (int k = 0; k < 50 && m_active; k++) tick();
        chk1("random_drained", m_active, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
